// File: rtl/lfsr_prbs_gen.sv
// lfsr_prbs_gen: parametrised Fibonacci LFSR pseudo-random word generator.
// The register advances OUT_WIDTH single steps per delivered word. Words are
// handed to a sink over a valid/ready handshake. The block also supports a
// runtime seed load, recovery from the all-zero lock-up state, and a
// wrapping counter of accepted words.
//
// Single step: next[WIDTH-1:1] = cur[WIDTH-2:0], next[0] = ^(cur & TAPS).
// out_data = state[OUT_WIDTH-1:0], so the first bit generated in a word
// ends up as its MSB.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   seed_load      load seed_value (zero is replaced by SEED) this cycle
//   seed_value     new seed, WIDTH bits
//   out_valid      out_data holds a valid word
//   out_ready      sink accepts the word
//   out_data       generated word, OUT_WIDTH bits
//   word_count     accepted words, wraps, COUNT_WIDTH bits
//   lockup_err     one-cycle pulse when a zero state is replaced by SEED
//
// Optional build macro LFSR_PRBS_CHECK_EN adds an independent checker LFSR:
//   chk_valid      a word to check is present on chk_data
//   chk_data       word under test, OUT_WIDTH bits
//   chk_err_count  saturating count of mismatching words, 16 bits

module lfsr_prbs_gen #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] TAPS        = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED        = {WIDTH{1'b1}},
  parameter int unsigned      OUT_WIDTH   = 8,
  parameter int unsigned      COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   seed_load,
  input  logic [WIDTH-1:0]       seed_value,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic [COUNT_WIDTH-1:0] word_count,
  output logic                   lockup_err
`ifdef LFSR_PRBS_CHECK_EN
  ,
  input  logic                   chk_valid,
  input  logic [OUT_WIDTH-1:0]   chk_data,
  output logic [15:0]            chk_err_count
`endif
);

  // Parameter legality, rejected at elaboration.
  if (WIDTH < 2 || WIDTH > 64) begin : g_err_width
    $error("lfsr_prbs_gen: WIDTH must be in 2..64");
  end
  if (OUT_WIDTH < 1 || OUT_WIDTH > WIDTH) begin : g_err_out_width
    $error("lfsr_prbs_gen: OUT_WIDTH must be in 1..WIDTH");
  end
  if (SEED == '0) begin : g_err_seed
    $error("lfsr_prbs_gen: SEED must be nonzero");
  end
  if (TAPS == '0) begin : g_err_taps
    $error("lfsr_prbs_gen: TAPS must be nonzero");
  end

  typedef enum logic [0:0] {
    S_PRIME = 1'b0,
    S_RUN   = 1'b1
  } fsm_e;

  // OUT_WIDTH single steps unrolled into one combinational word step.
  function automatic logic [WIDTH-1:0] word_step(input logic [WIDTH-1:0] cur);
    logic [WIDTH-1:0] s;
    s = cur;
    for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
      s = {s[WIDTH-2:0], ^(s & TAPS)};
    end
    return s;
  endfunction

  fsm_e                   fsm_q;
  logic [WIDTH-1:0]       state_q;
  logic                   out_valid_q;
  logic [COUNT_WIDTH-1:0] word_count_q;
  logic                   lockup_err_q;

  logic [WIDTH-1:0]       step_c;
  logic [WIDTH-1:0]       load_val_c;
  logic                   seed_zero_c;
  logic                   xfer_c;
  logic                   state_zero_c;

  // Next word state, seed substitution and handshake qualifiers.
  always_comb begin
    step_c       = word_step(state_q);
    seed_zero_c  = (seed_value == '0);
    load_val_c   = seed_zero_c ? SEED : seed_value;
    xfer_c       = out_valid_q & out_ready;
    state_zero_c = (state_q == '0);
  end

  // Generator FSM: PRIME computes the first word of a sequence, RUN advances
  // only when the sink takes the current word. A transfer is always counted,
  // even when a seed load in the same cycle replaces the following word.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= S_PRIME;
      state_q      <= SEED;
      out_valid_q  <= 1'b0;
      word_count_q <= '0;
      lockup_err_q <= 1'b0;
    end else begin
      lockup_err_q <= 1'b0;
      if (xfer_c) begin
        word_count_q <= word_count_q + COUNT_WIDTH'(1);
      end
      if (seed_load) begin
        state_q      <= load_val_c;
        lockup_err_q <= seed_zero_c;
        out_valid_q  <= 1'b0;
        fsm_q        <= S_PRIME;
      end else if (state_zero_c) begin
        // A zero state would stick forever; restart from SEED.
        state_q      <= SEED;
        lockup_err_q <= 1'b1;
        out_valid_q  <= 1'b0;
        fsm_q        <= S_PRIME;
      end else begin
        case (fsm_q)
          S_PRIME: begin
            state_q     <= step_c;
            out_valid_q <= 1'b1;
            fsm_q       <= S_RUN;
          end
          S_RUN: begin
            if (xfer_c) begin
              state_q <= step_c;
            end
          end
          default: begin
            fsm_q       <= S_PRIME;
            out_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = state_q[OUT_WIDTH-1:0];
  assign word_count = word_count_q;
  assign lockup_err = lockup_err_q;

`ifdef LFSR_PRBS_CHECK_EN
  logic [WIDTH-1:0]     chk_q;
  logic [WIDTH-1:0]     chk_step_c;
  logic [OUT_WIDTH-1:0] chk_exp_c;
  logic [15:0]          chk_err_q;

  // Expected word is the low slice of the checker's next state.
  always_comb begin
    chk_step_c = word_step(chk_q);
    chk_exp_c  = chk_step_c[OUT_WIDTH-1:0];
  end

  // Checker LFSR tracks the stream independently; seed_load wins over a check.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q     <= SEED;
      chk_err_q <= '0;
    end else if (seed_load) begin
      chk_q <= load_val_c;
    end else if (chk_valid) begin
      chk_q <= chk_step_c;
      if ((chk_data != chk_exp_c) && (chk_err_q != 16'hFFFF)) begin
        chk_err_q <= chk_err_q + 16'(1);
      end
    end
  end

  assign chk_err_count = chk_err_q;
`endif

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Self-checking bench for lfsr_prbs_gen. The reference model treats the
// generator as a bit stream defined by the recurrence
// b[n] = XOR of b[n-1-i] for each tap i, packed MSB-first into words.
module tb_lfsr_prbs_gen;

  localparam int unsigned W    = 8;
  localparam int unsigned OW   = 8;
  localparam logic [7:0]  TAPS = 8'hB8;
  localparam logic [7:0]  SEED = 8'hFF;
  localparam int          N1   = 600;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [7:0]  seed_value;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [31:0] word_count;
  logic        lockup_err;

  logic        rst1;
  logic        v1;
  logic [0:0]  d1;
  logic [31:0] cnt1;
  logic        lock1;

`ifdef LFSR_PRBS_CHECK_EN
  logic        chk_loop;
  logic        chk_valid;
  logic [7:0]  chk_data;
  logic [15:0] chk_err_count;
  logic [15:0] chk1_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lfsr_prbs_gen u_dut (
    .clk          (clk),
    .rst          (rst),
    .seed_load    (seed_load),
    .seed_value   (seed_value),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .word_count   (word_count),
    .lockup_err   (lockup_err)
`ifdef LFSR_PRBS_CHECK_EN
    ,
    .chk_valid    (chk_valid),
    .chk_data     (chk_data),
    .chk_err_count(chk_err_count)
`endif
  );

  lfsr_prbs_gen #(.OUT_WIDTH(1)) u_dut1 (
    .clk          (clk),
    .rst          (rst1),
    .seed_load    (1'b0),
    .seed_value   (8'h00),
    .out_valid    (v1),
    .out_ready    (1'b1),
    .out_data     (d1),
    .word_count   (cnt1),
    .lockup_err   (lock1)
`ifdef LFSR_PRBS_CHECK_EN
    ,
    .chk_valid    (1'b0),
    .chk_data     (1'b0),
    .chk_err_count(chk1_err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          hist[$];
  logic        m_valid;
  logic        m_prime;
  logic        m_lock;
  logic [7:0]  m_data;
  logic [31:0] m_count;

  // Register state s corresponds to the last W stream bits, s[0] newest.
  function automatic void m_load(input logic [7:0] s);
    hist.delete();
    for (int i = W - 1; i >= 0; i--) hist.push_back(s[i]);
  endfunction

  function automatic bit m_bit();
    bit nb = 1'b0;
    int n  = hist.size();
    for (int i = 0; i < W; i++) if (TAPS[i]) nb ^= hist[n-1-i];
    hist.push_back(nb);
    if (hist.size() > 64) void'(hist.pop_front());
    return nb;
  endfunction

  function automatic logic [7:0] m_word();
    logic [7:0] w = 8'h00;
    for (int k = 0; k < OW; k++) w = {w[6:0], m_bit()};
    return w;
  endfunction

  task automatic m_edge();
    if (rst) begin
      m_load(SEED);
      m_prime = 1'b1;
      m_valid = 1'b0;
      m_count = '0;
      m_lock  = 1'b0;
      m_data  = SEED;
    end else begin
      if (m_valid && out_ready) m_count = m_count + 32'd1;
      if (seed_load) begin
        m_load((seed_value == 8'h00) ? SEED : seed_value);
        m_lock  = (seed_value == 8'h00);
        m_valid = 1'b0;
        m_prime = 1'b1;
      end else begin
        m_lock = 1'b0;
        if (m_prime) begin
          m_data  = m_word();
          m_valid = 1'b1;
          m_prime = 1'b0;
        end else if (m_valid && out_ready) begin
          m_data = m_word();
        end
      end
    end
  endtask

  // One clock: drive checker loopback, advance model at the edge, compare.
  task automatic tick();
`ifdef LFSR_PRBS_CHECK_EN
    chk_valid = chk_loop && out_valid && out_ready;
    chk_data  = out_data ^ ((word_count == 32'd2) ? 8'h01 : 8'h00);
`endif
    @(posedge clk);
    m_edge();
    #1;
    check("valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) check("data", 64'(out_data), 64'(m_data));
    check("count", 64'(word_count), 64'(m_count));
    check("lockup", 64'(lockup_err), 64'(m_lock));
  endtask

  // Record the 1-bit instance's stream.
  bit bits1[N1];
  int n1 = 0;
  always @(posedge clk) begin
    #1;
    if (!rst1 && v1 && n1 < N1) begin
      bits1[n1] = d1[0];
      n1++;
    end
  end

  initial begin
    logic [7:0]  held_d;
    logic [31:0] held_c;
    logic [7:0]  exp8;
    int          guard;

    rst = 1'b1; rst1 = 1'b1; seed_load = 1'b0; seed_value = 8'h00; out_ready = 1'b0;
`ifdef LFSR_PRBS_CHECK_EN
    chk_loop = 1'b0; chk_valid = 1'b0; chk_data = 8'h00;
`endif
    m_load(SEED); m_valid = 0; m_prime = 1; m_lock = 0; m_count = 0; m_data = SEED;

    tick(); tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(word_count), 64'd0);
    check("rst_lockup", 64'(lockup_err), 64'd0);
    check("rst_data", 64'(out_data), 64'hFF);

    rst = 1'b0; rst1 = 1'b0; out_ready = 1'b1;
`ifdef LFSR_PRBS_CHECK_EN
    chk_loop = 1'b1;
`endif
    tick();
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_word", 64'(out_data), 64'h0B);
    tick();
    check("count_after_first", 64'(word_count), 64'd1);

    guard = 0;
    while (m_count != 32'd255 && guard < 1000) begin tick(); guard++; end
    check("wait_255_bound", 64'(guard < 1000), 64'd1);
    check("word256", 64'(out_data), 64'h0B);
    tick();
    check("count256", 64'(word_count), 64'd256);
`ifdef LFSR_PRBS_CHECK_EN
    chk_loop = 1'b0;
    check("chk_err_count", 64'(chk_err_count), 64'd1);
`endif

    // Backpressure
    repeat (3) tick();
    out_ready = 1'b0;
    held_d = out_data; held_c = word_count;
    repeat (5) begin
      tick();
      check("bp_data_hold", 64'(out_data), 64'(held_d));
      check("bp_count_hold", 64'(word_count), 64'(held_c));
      check("bp_valid_hold", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    check("bp_resume_count", 64'(word_count), 64'(held_c + 32'd1));

    // Zero seed triggers lock-up recovery
    out_ready = 1'b0; seed_load = 1'b1; seed_value = 8'h00;
    tick();
    check("lock_pulse", 64'(lockup_err), 64'd1);
    check("lock_valid_low", 64'(out_valid), 64'd0);
    seed_load = 1'b0; out_ready = 1'b1;
    tick();
    check("lock_clear", 64'(lockup_err), 64'd0);
    check("seed0_word", 64'(out_data), 64'h0B);

    // Seed load coinciding with a transfer
    held_c = word_count;
    seed_load = 1'b1; seed_value = 8'hFF;
    tick();
    check("seed_xfer_count", 64'(word_count), 64'(held_c + 32'd1));
    check("seed_valid_drop", 64'(out_valid), 64'd0);
    seed_load = 1'b0;
    tick();
    check("seed_ff_valid", 64'(out_valid), 64'd1);
    check("seed_ff_word", 64'(out_data), 64'h0B);

    // Randomised traffic
    repeat (3000) begin
      rst        = ($urandom_range(0, 499) == 0);
      seed_load  = ($urandom_range(0, 49) == 0);
      seed_value = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0; seed_load = 1'b0; out_ready = 1'b1;
    tick();

    // One-bit-per-word instance
    check("bit1_samples", 64'(n1), 64'(N1));
    exp8 = 8'b0000_1011;
    for (int k = 0; k < 8; k++) begin
      check("bit1_first", 64'(bits1[k]), 64'(exp8[7-k]));
      check("bit1_period", 64'(bits1[k+255]), 64'(exp8[7-k]));
    end
    m_load(SEED);
    for (int k = 0; k < N1; k++) check("bit1_model", 64'(bits1[k]), 64'(m_bit()));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
